// File: rtl/sram1rw_pkg.sv
// Shared types and default geometry for the 1RW SRAM front end.
package sram1rw_pkg;
  localparam int SRAM_ADDR_W = 7;
  localparam int SRAM_DATA_W = 40;
  localparam int SRAM_WORDS  = 128;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic                   csb;
    logic                   web;
    logic                   oeb;
    logic [SRAM_ADDR_W-1:0] a;
    logic [SRAM_DATA_W-1:0] i;
    logic                   is_rd;
  } issue_t;
endpackage

// File: rtl/sram1rw_resp_fifo.sv
// Read-response FIFO; occupancy is bounded upstream by the credit check.
module sram1rw_resp_fifo #(
  parameter int DATA_W = 40,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= nxt(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= nxt(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/sram1rw_ctrl.sv
// Client front end for a 1RW SRAM macro: zero sweep after reset, registered
// macro pins, and credit-limited read responses that survive backpressure.
module sram1rw_ctrl
  import sram1rw_pkg::*;
#(
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int DATA_W     = SRAM_DATA_W,
  parameter int WORDS      = SRAM_WORDS,
  parameter int RESP_DEPTH = 4,
  parameter int ZERO_INIT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o
);
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int OCC_W = CNT_W + 2;
  localparam state_e RST_STATE = (ZERO_INIT != 0) ? ST_INIT : ST_RUN;
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(WORDS - 1);
  localparam issue_t ISS_RST = '{csb: 1'b1, web: 1'b1, oeb: 1'b1,
                                 a: '0, i: '0, is_rd: 1'b0};

  state_e          state_q, state_d;
  logic [ADDR_W:0] sweep_q, sweep_d;
  issue_t          iss_q, iss_d;
  logic            mac_rd_q;
  logic [CNT_W-1:0] fifo_count;
  logic            fifo_empty, fifo_full, fifo_push;
  logic [OCC_W-1:0] occ;
  logic            accept;

  // Credit counts everything already committed to land in the FIFO; using the
  // registered count keeps resp_ready out of the req_ready path.
  assign occ       = OCC_W'(fifo_count) + OCC_W'(iss_q.is_rd) + OCC_W'(mac_rd_q);
  assign req_ready = (state_q == ST_RUN) && (req_write || (occ < OCC_W'(RESP_DEPTH)));
  assign accept    = req_valid && req_ready;
  assign init_done = (state_q == ST_RUN);

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    iss_d       = iss_q;
    iss_d.csb   = 1'b1;
    iss_d.web   = 1'b1;
    iss_d.oeb   = 1'b1;
    iss_d.is_rd = 1'b0;
    case (state_q)
      ST_INIT: begin
        iss_d.csb = 1'b0;
        iss_d.web = 1'b0;
        iss_d.a   = sweep_q[ADDR_W-1:0];
        iss_d.i   = '0;
        sweep_d   = sweep_q + (ADDR_W + 1)'(1);
        if (sweep_q == LAST_ADDR) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (accept) begin
          iss_d.csb   = 1'b0;
          iss_d.web   = !req_write;
          iss_d.oeb   = req_write;
          iss_d.a     = req_addr;
          iss_d.i     = req_wdata;
          iss_d.is_rd = !req_write;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RST_STATE;
      sweep_q  <= '0;
      iss_q    <= ISS_RST;
      mac_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      iss_q    <= iss_d;
      mac_rd_q <= iss_q.is_rd;
    end
  end

  assign sram_csb = iss_q.csb;
  assign sram_web = iss_q.web;
  assign sram_oeb = iss_q.oeb;
  assign sram_a   = iss_q.a;
  assign sram_i   = iss_q.i;

  // sram_o is valid one edge after the macro read, i.e. when the flag reaches mac_rd_q.
  assign fifo_push  = mac_rd_q && (!fifo_full || resp_ready);
  assign resp_valid = !fifo_empty;

  sram1rw_resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RESP_DEPTH)
  ) u_resp_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i (sram_o),
    .pop_i   (resp_ready),
    .rdata_o (resp_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );
endmodule
